// File: rtl/alu_multi_irq.sv
// alu_multi_irq: NUM_CH channels share one registered ALU; each channel owns a programmable
// trigger table whose hits raise a sticky, per-channel-clearable interrupt. Optional macro
// ALU_IRQ_CNT_EN adds saturating 8-bit per-channel match counters on alu_irq_cnt.
module alu_multi_irq #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned TRIG_DEPTH = 4,
  parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned TI_W       = (TRIG_DEPTH > 1) ? $clog2(TRIG_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              alu_rst_n,
  input  logic              alu_enable,
  input  logic [NUM_CH-1:0] alu_enable_ch,
  input  logic [DATA_W-1:0] alu_in_a,
  input  logic [DATA_W-1:0] alu_in_b,
  input  logic [2:0]        alu_op,
  input  logic              trig_we,
  input  logic [CH_W-1:0]   trig_ch,
  input  logic [TI_W-1:0]   trig_idx,
  input  logic              trig_val,
  input  logic [DATA_W-1:0] trig_data,
  input  logic              alu_irq_clr,
  input  logic [NUM_CH-1:0] alu_irq_clr_mask,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_out_vld,
  output logic [CH_W-1:0]   alu_out_ch,
  output logic              alu_err,
  output logic [NUM_CH-1:0] alu_irq_pend,
  output logic              alu_irq
`ifdef ALU_IRQ_CNT_EN
  ,
  output logic [NUM_CH*8-1:0] alu_irq_cnt
`endif
);

  localparam int unsigned N_ENT = NUM_CH * TRIG_DEPTH;
  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_XNOR = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_SUB  = 3'd7;

  logic              trig_vld_q  [NUM_CH][TRIG_DEPTH];
  logic [DATA_W-1:0] trig_data_q [NUM_CH][TRIG_DEPTH];

  logic              issue_c;
  logic              illegal_c;
  logic [CH_W-1:0]   issue_ch_c;
  logic [DATA_W-1:0] result_c;
  logic [N_ENT-1:0]  ent_hit_c;
  logic [NUM_CH-1:0] ch_hit_c;
  logic [NUM_CH-1:0] set_c;
  logic [NUM_CH-1:0] clr_c;
  logic [NUM_CH-1:0] pend_nxt_c;
  logic              trig_wr_c;

  // Issue qualification and channel index encode
  always_comb begin : decode
    issue_ch_c = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (alu_enable_ch[CH_W'(c)]) issue_ch_c = CH_W'(c);
    end
    issue_c   = alu_enable && $onehot(alu_enable_ch);
    illegal_c = alu_enable && !$onehot0(alu_enable_ch);
  end

  // Shared datapath; ADD/SUB wrap modulo 2^DATA_W
  always_comb begin : datapath
    result_c = '0;
    unique case (alu_op)
      OP_AND:  result_c = alu_in_a & alu_in_b;
      OP_NAND: result_c = ~(alu_in_a & alu_in_b);
      OP_OR:   result_c = alu_in_a | alu_in_b;
      OP_XOR:  result_c = alu_in_a ^ alu_in_b;
      OP_XNOR: result_c = ~(alu_in_a ^ alu_in_b);
      OP_NOR:  result_c = ~(alu_in_a | alu_in_b);
      OP_ADD:  result_c = alu_in_a + alu_in_b;
      OP_SUB:  result_c = alu_in_a - alu_in_b;
      default: result_c = '0;
    endcase
  end

  // Entry hits are gated by the channel's enable bit, so only the issuing channel can match
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar i = 0; i < TRIG_DEPTH; i++) begin : g_ent
      assign ent_hit_c[c*TRIG_DEPTH + i] = trig_vld_q[c][i] && (trig_data_q[c][i] == result_c);
    end
    assign ch_hit_c[c] = alu_enable_ch[c] && (|ent_hit_c[c*TRIG_DEPTH +: TRIG_DEPTH]);
  end

  // Set has priority over clear on the same channel
  always_comb begin : pend_next
    set_c      = issue_c ? ch_hit_c : '0;
    clr_c      = alu_irq_clr ? alu_irq_clr_mask : '0;
    pend_nxt_c = (alu_irq_pend & ~clr_c) | set_c;
    trig_wr_c  = trig_we && (32'(trig_ch) < NUM_CH) && (32'(trig_idx) < TRIG_DEPTH);
  end

  // Result, status and interrupt registers
  always_ff @(posedge clk) begin : out_regs
    if (!alu_rst_n) begin
      alu_out      <= '0;
      alu_out_vld  <= 1'b0;
      alu_out_ch   <= '0;
      alu_err      <= 1'b0;
      alu_irq_pend <= '0;
      alu_irq      <= 1'b0;
    end else begin
      alu_out_vld  <= issue_c;
      alu_err      <= illegal_c;
      if (issue_c) begin
        alu_out    <= result_c;
        alu_out_ch <= issue_ch_c;
      end
      alu_irq_pend <= pend_nxt_c;
      alu_irq      <= |pend_nxt_c;
    end
  end

  // Trigger table; a compare in the write cycle still sees the old entry
  always_ff @(posedge clk) begin : trig_table
    if (!alu_rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned i = 0; i < TRIG_DEPTH; i++) begin
          trig_vld_q[CH_W'(c)][TI_W'(i)]  <= 1'b0;
          trig_data_q[CH_W'(c)][TI_W'(i)] <= '0;
        end
      end
    end else if (trig_wr_c) begin
      trig_vld_q[trig_ch][trig_idx]  <= trig_val;
      trig_data_q[trig_ch][trig_idx] <= trig_data;
    end
  end

`ifdef ALU_IRQ_CNT_EN
  // Saturating match counters, cleared with their pend bit; a coinciding match leaves 1
  always_ff @(posedge clk) begin : irq_cnt_regs
    if (!alu_rst_n) begin
      alu_irq_cnt <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (clr_c[CH_W'(c)]) begin
          alu_irq_cnt[c*CNT_W +: CNT_W] <= set_c[CH_W'(c)] ? CNT_W'(1) : CNT_W'(0);
        end else if (set_c[CH_W'(c)] && (alu_irq_cnt[c*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          alu_irq_cnt[c*CNT_W +: CNT_W] <= alu_irq_cnt[c*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_multi_irq.sv
// Scoreboard bench for alu_multi_irq: behavioural model predicts every registered output each cycle.
module tb_alu_multi_irq;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned TRIG_DEPTH = 4;
  localparam int unsigned CH_W       = 1;
  localparam int unsigned TI_W       = 2;

  logic              clk = 1'b0;
  logic              alu_rst_n;
  logic              alu_enable;
  logic [NUM_CH-1:0] alu_enable_ch;
  logic [DATA_W-1:0] alu_in_a, alu_in_b;
  logic [2:0]        alu_op;
  logic              trig_we;
  logic [CH_W-1:0]   trig_ch;
  logic [TI_W-1:0]   trig_idx;
  logic              trig_val;
  logic [DATA_W-1:0] trig_data;
  logic              alu_irq_clr;
  logic [NUM_CH-1:0] alu_irq_clr_mask;
  logic [DATA_W-1:0] alu_out;
  logic              alu_out_vld;
  logic [CH_W-1:0]   alu_out_ch;
  logic              alu_err;
  logic [NUM_CH-1:0] alu_irq_pend;
  logic              alu_irq;
`ifdef ALU_IRQ_CNT_EN
  logic [NUM_CH*8-1:0] alu_irq_cnt;
`endif

  always #5 clk = ~clk;

  alu_multi_irq #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .TRIG_DEPTH(TRIG_DEPTH)) dut (
    .clk              (clk),
    .alu_rst_n        (alu_rst_n),
    .alu_enable       (alu_enable),
    .alu_enable_ch    (alu_enable_ch),
    .alu_in_a         (alu_in_a),
    .alu_in_b         (alu_in_b),
    .alu_op           (alu_op),
    .trig_we          (trig_we),
    .trig_ch          (trig_ch),
    .trig_idx         (trig_idx),
    .trig_val         (trig_val),
    .trig_data        (trig_data),
    .alu_irq_clr      (alu_irq_clr),
    .alu_irq_clr_mask (alu_irq_clr_mask),
    .alu_out          (alu_out),
    .alu_out_vld      (alu_out_vld),
    .alu_out_ch       (alu_out_ch),
    .alu_err          (alu_err),
    .alu_irq_pend     (alu_irq_pend),
    .alu_irq          (alu_irq)
`ifdef ALU_IRQ_CNT_EN
    ,
    .alu_irq_cnt      (alu_irq_cnt)
`endif
  );

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [CH_W-1:0]   ch;
  } exp_t;

  exp_t sb_q[$];

  logic              m_tv [NUM_CH][TRIG_DEPTH];
  logic [DATA_W-1:0] m_td [NUM_CH][TRIG_DEPTH];
  logic [NUM_CH-1:0] m_pend;
  logic [DATA_W-1:0] m_out;
  logic [CH_W-1:0]   m_ch;
  logic              m_vld, m_err;
  int                m_cnt [NUM_CH];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] alu_ref(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return ~(a ^ b);
      3'd5: return ~(a | b);
      3'd6: return DATA_W'(a + b);
      default: return DATA_W'(a - b);
    endcase
  endfunction

  task automatic idle();
    alu_enable = 1'b0; alu_enable_ch = '0; alu_op = '0; alu_in_a = '0; alu_in_b = '0;
    trig_we = 1'b0; trig_ch = '0; trig_idx = '0; trig_val = 1'b0; trig_data = '0;
    alu_irq_clr = 1'b0; alu_irq_clr_mask = '0;
  endtask

  task automatic set_issue(input int ch, input logic [2:0] op,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    alu_enable = 1'b1; alu_enable_ch = NUM_CH'(1) << ch;
    alu_op = op; alu_in_a = a; alu_in_b = b;
  endtask

  task automatic set_trig(input int ch, input int idx, input logic v, input logic [DATA_W-1:0] d);
    trig_we = 1'b1; trig_ch = CH_W'(ch); trig_idx = TI_W'(idx); trig_val = v; trig_data = d;
  endtask

  task automatic set_clr(input logic [NUM_CH-1:0] mask);
    alu_irq_clr = 1'b1; alu_irq_clr_mask = mask;
  endtask

  // Advance the model over one edge, then compare every output against it
  task automatic step();
    logic [DATA_W-1:0] r;
    logic [NUM_CH-1:0] clr;
    int ch;
    bit hit;
    exp_t e;
    hit = 0; ch = 0;
    if (!alu_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < TRIG_DEPTH; i++) begin m_tv[c][i] = 1'b0; m_td[c][i] = '0; end
        m_cnt[c] = 0;
      end
      m_pend = '0; m_out = '0; m_ch = '0; m_vld = 1'b0; m_err = 1'b0;
      sb_q.delete();
    end else begin
      m_vld = 1'b0; m_err = 1'b0;
      if (alu_enable && $countones(alu_enable_ch) == 1) begin
        for (int c = 0; c < NUM_CH; c++) if (alu_enable_ch[c]) ch = c;
        r = alu_ref(alu_op, alu_in_a, alu_in_b);
        for (int i = 0; i < TRIG_DEPTH; i++) if (m_tv[ch][i] && m_td[ch][i] == r) hit = 1;
        sb_q.push_back('{res: r, ch: CH_W'(ch)});
        m_vld = 1'b1; m_out = r; m_ch = CH_W'(ch);
      end else if (alu_enable && $countones(alu_enable_ch) >= 2) begin
        m_err = 1'b1;
      end
      clr = alu_irq_clr ? alu_irq_clr_mask : '0;
      for (int c = 0; c < NUM_CH; c++) if (clr[c]) begin m_pend[c] = 1'b0; m_cnt[c] = 0; end
      if (hit) begin
        m_pend[ch] = 1'b1;
        m_cnt[ch]  = (m_cnt[ch] >= 255) ? 255 : m_cnt[ch] + 1;
      end
      if (trig_we && int'(trig_ch) < NUM_CH && int'(trig_idx) < TRIG_DEPTH) begin
        m_tv[trig_ch][trig_idx] = trig_val;
        m_td[trig_ch][trig_idx] = trig_data;
      end
    end
    @(posedge clk);
    #1;
    check("vld", alu_out_vld, m_vld);
    check("err", alu_err, m_err);
    if (alu_out_vld) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("out", alu_out, e.res);
        check("out_ch", alu_out_ch, e.ch);
      end
    end
    check("out_hold", alu_out, m_out);
    check("ch_hold", alu_out_ch, m_ch);
    check("pend", alu_irq_pend, m_pend);
    check("irq", alu_irq, |m_pend);
`ifdef ALU_IRQ_CNT_EN
    for (int c = 0; c < NUM_CH; c++) check("cnt", alu_irq_cnt[c*8 +: 8], m_cnt[c]);
`endif
  endtask

  logic [DATA_W-1:0] dp_exp [8] = '{8'h30, 8'hCF, 8'hFC, 8'hCC, 8'h33, 8'h03, 8'h2C, 8'hB4};

  initial begin
    idle();
    alu_rst_n = 1'b0;
    step();
    check("rst_out", alu_out, 0);
    check("rst_pend", alu_irq_pend, 0);
    alu_rst_n = 1'b1;

    // Reset flushes programmed triggers and an in-flight result
    set_trig(0, 0, 1'b1, 8'h11); step(); idle();
    set_issue(0, 3'd6, 8'h10, 8'h01); step();
    check("pre_rst_pend", alu_irq_pend, 2'b01);
    alu_rst_n = 1'b0; step();
    check("rst_vld", alu_out_vld, 0);
    check("rst_out2", alu_out, 0);
    check("rst_irq", alu_irq, 0);
    alu_rst_n = 1'b1; step(); idle();
    check("post_rst_out", alu_out, 8'h11);
    check("post_rst_pend", alu_irq_pend, 2'b00);

    // Datapath sweep, then ADD wrap
    for (int op = 0; op < 8; op++) begin
      set_issue(0, 3'(op), 8'hF0, 8'h3C); step();
      check("dp_const", alu_out, dp_exp[op]);
    end
    set_issue(0, 3'd6, 8'hFF, 8'h01); step(); idle();
    check("add_wrap", alu_out, 8'h00);

    // Interrupt raise and masked clear
    set_trig(1, 2, 1'b1, 8'hF5); step(); idle();
    set_issue(1, 3'd2, 8'hF0, 8'h05); step(); idle();
    check("irq_pend_set", alu_irq_pend, 2'b10);
    check("irq_set", alu_irq, 1);
    set_clr(2'b01); step(); idle();
    check("clr_other", alu_irq_pend, 2'b10);
    set_clr(2'b10); step(); idle();
    check("clr_own", alu_irq_pend, 2'b00);

    // Set beats clear; same-edge write sees old entry
    set_trig(0, 1, 1'b1, 8'hAA); step(); idle();
    set_issue(0, 3'd2, 8'hAA, 8'h00); set_clr(2'b01); step(); idle();
    check("set_wins", alu_irq_pend, 2'b01);
    set_clr(2'b11); step(); idle();
    set_issue(0, 3'd2, 8'hAA, 8'h00); set_trig(0, 1, 1'b1, 8'h55); step(); idle();
    check("old_entry", alu_irq_pend, 2'b01);
    set_clr(2'b11); step(); idle();
    set_issue(0, 3'd2, 8'hAA, 8'h00); step(); idle();
    check("stale_gone", alu_irq_pend, 2'b00);
    set_issue(0, 3'd2, 8'h55, 8'h00); step(); idle();
    check("new_entry", alu_irq_pend, 2'b01);
    set_clr(2'b11); step(); idle();

    // Illegal enable and idle with a table write
    set_issue(0, 3'd0, 8'hF0, 8'h3C); step();
    alu_enable_ch = 2'b11; step(); idle();
    check("illegal_err", alu_err, 1);
    check("illegal_vld", alu_out_vld, 0);
    check("illegal_hold", alu_out, 8'h30);
    alu_enable_ch = 2'b01; set_trig(1, 0, 1'b1, 8'h77); step(); idle();
    check("idle_hold", alu_out, 8'h30);
    set_issue(1, 3'd2, 8'h70, 8'h07); step(); idle();
    check("idle_write", alu_irq_pend, 2'b10);
    set_clr(2'b11); step(); idle();

`ifdef ALU_IRQ_CNT_EN
    set_trig(0, 3, 1'b1, 8'h42); step(); idle();
    for (int k = 0; k < 300; k++) begin set_issue(0, 3'd0, 8'h42, 8'hFF); step(); end
    idle();
    check("cnt_sat", alu_irq_cnt[7:0], 255);
    set_clr(2'b01); step(); idle();
    check("cnt_clr", alu_irq_cnt[7:0], 0);
`endif

    // Randomised traffic with a narrow value set so triggers hit often
    for (int k = 0; k < 400; k++) begin
      idle();
      alu_enable    = ($urandom_range(0, 7) != 0);
      alu_enable_ch = NUM_CH'($urandom_range(0, 3));
      alu_op        = 3'($urandom_range(0, 7));
      alu_in_a      = DATA_W'($urandom_range(0, 3));
      alu_in_b      = DATA_W'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        set_trig($urandom_range(0, 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 DATA_W'($urandom_range(0, 7)));
      if ($urandom_range(0, 5) == 0) set_clr(NUM_CH'($urandom_range(0, 3)));
      alu_rst_n = ($urandom_range(0, 63) != 0);
      step();
      alu_rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_multi_irq.md
# alu_multi_irq

Parametrised multi-channel ALU with programmable interrupt triggers, the next generation of the two-channel (a/b) ALU in the verification environment. NUM_CH channels share one registered datapath. Each channel owns a trigger table of result values that raise a sticky, per-channel-clearable interrupt. It replaces the fixed per-channel trigger constants with runtime-programmable ones and adds illegal-enable reporting.

## Interface
- DATA_W, 8, operand/result width (≥2)
- NUM_CH, 2, channel count (≥1)
- TRIG_DEPTH, 4, trigger entries per channel (≥1)
- CH_W, derived = max(1, $clog2(NUM_CH)), channel index width
- TI_W, derived = max(1, $clog2(TRIG_DEPTH)), trigger index width
- clk  in  1  single clock, rising edge
- alu_rst_n  in  1  reset, synchronous, active-low
- alu_enable  in  1  global enable
- alu_enable_ch  in  NUM_CH  one-hot channel select
- alu_in_a, alu_in_b  in  DATA_W  operands
- alu_op  in  3  opcode
- trig_we  in  1  trigger table write strobe
- trig_ch  in  CH_W  table channel
- trig_idx  in  TI_W  table entry
- trig_val  in  1  entry valid bit to write
- trig_data  in  DATA_W  entry value
- alu_irq_clr  in  1  clear strobe
- alu_irq_clr_mask  in  NUM_CH  channels to clear
- alu_out  out  DATA_W  registered result
- alu_out_vld  out  1  result-valid pulse
- alu_out_ch  out  CH_W  channel of alu_out
- alu_err  out  1  illegal-enable pulse
- alu_irq_pend  out  NUM_CH  sticky per-channel pending
- alu_irq  out  1  OR of alu_irq_pend

## Operation
- Issue condition: alu_enable=1 and alu_enable_ch exactly one-hot. The issuing channel is the index of the set bit.
- Idle: alu_enable=0 or alu_enable_ch=0. alu_out/alu_out_ch hold; vld=0.
- Illegal: alu_enable=1 and popcount(alu_enable_ch)≥2. No issue; alu_out holds; alu_err=1 for that cycle's result slot.
- Opcodes: 0 AND, 1 NAND, 2 OR, 3 XOR, 4 XNOR, 5 NOR, 6 ADD, 7 SUB. ADD/SUB are modulo 2^DATA_W; carry/borrow discarded.
- Trigger table: NUM_CH×TRIG_DEPTH entries of {valid, value}. trig_we writes {trig_val, trig_data} at [trig_ch][trig_idx]. Out-of-range trig_ch/trig_idx writes are ignored. Writes are accepted regardless of alu_enable.
- Match: the new result equals any valid entry of the issuing channel. The match sets alu_irq_pend[ch].
- Clear: alu_irq_clr=1 clears the pend bits selected by the mask. Mask is ignored when alu_irq_clr=0.
- Set and clear on the same channel in the same cycle: set wins.
- Repeated matches on a pending channel keep it at 1 (no toggle).

## Timing
- Reset (alu_rst_n=0 at an edge): alu_out=0, alu_out_vld=0, alu_out_ch=0, alu_err=0, alu_irq_pend=0, alu_irq=0, all trigger entries invalid.
- Reset mid-operation: a result sampled in the reset cycle is discarded. The first issue after deassertion is sampled at the first edge with alu_rst_n=1.
- Latency 1: inputs sampled at edge N produce, at N, alu_out/alu_out_ch/alu_out_vld=1. If matched, alu_irq_pend and alu_irq are also 1 at N.
- alu_out_vld and alu_err are single-cycle pulses. Back-to-back issues give a continuous vld.
- A trigger write and a compare at the same edge on the same entry: the compare uses the old entry. The new value is effective from N+1.
- Clear sampled at edge N: pend=0 after N, unless a match occurs at N.

## Configuration
- ALU_IRQ_CNT_EN defined: adds output alu_irq_cnt (NUM_CH×8). Each 8-bit counter increments on every match of its channel and saturates at 255. The counter clears when that channel's pend bit is cleared; if a match coincides with the clear, the counter is 1. Counters reset to 0.
- Not defined: no counter port, no counter logic; all other behaviour identical.

## Test plan
- Reset: drive activity, assert alu_rst_n=0 one edge -> all outputs 0, and a previously programmed trigger value no longer raises irq.
- Datapath: ch0, a=8'hF0, b=8'h3C, ops 0–7 -> alu_out 30, CF, FC, CC, 33, 03, 2C, B4 on successive cycles with vld=1; then ADD 8'hFF+8'h01 -> 00.
- IRQ/clear: table[1][2]={1,8'hF5}; ch1 result F5 -> alu_irq_pend=2'b10 and alu_irq=1 at the same edge. Clear with mask 2'b01 -> still 10; mask 2'b10 -> 00.
- Simultaneous set/clear: ch0 match in the same cycle as clear mask 2'b01 -> pend[0] stays 1. Write and compare on the same entry at the same edge -> old value used.
- Illegal/idle: alu_enable_ch=2'b11 -> alu_err pulse, alu_out unchanged, vld=0. alu_enable=0 -> alu_out held, trig writes still take effect.
- ALU_IRQ_CNT_EN: 300 consecutive matches on ch0 -> count 255; clear -> 0.
